// File: rtl/maxpool_2x2_stream.sv
// Stride-2 2x2 max-pool over a row/column/group ordered 128-bit feature stream.
// Optional MAXPOOL_SIGNED_EN selects signed int8 lane compare; default is unsigned.
module maxpool_2x2_stream #(
  parameter int DATA_WIDTH = 128,
  parameter int LANE_WIDTH = 8,
  parameter int MAX_WIDTH  = 416,
  parameter int MAX_GROUPS = 32,
  parameter int DIM_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            Control,
  output logic [3:0]            State,
  input  logic [DIM_WIDTH-1:0]  cfg_width,
  input  logic [DIM_WIDTH-1:0]  cfg_height,
  input  logic [5:0]            cfg_groups,
  input  logic [DATA_WIDTH-1:0] S_Data,
  input  logic                  S_Valid,
  output logic                  S_Ready,
  output logic [DATA_WIDTH-1:0] M_Data,
  output logic                  M_Valid,
  input  logic                  M_Ready,
  output logic                  done_pulse
);

  localparam int LANES  = DATA_WIDTH / LANE_WIDTH;
  localparam int DEPTH  = (MAX_WIDTH / 2) * MAX_GROUPS;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int GI_W   = $clog2(MAX_GROUPS);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0000,
    ST_RUN   = 4'b0001,
    ST_DRAIN = 4'b0010,
    ST_DONE  = 4'b1111
  } state_t;

  state_t state, state_next;

  logic [DIM_WIDTH-1:0]  w_r, h_r, c_cnt, r_cnt;
  logic [5:0]            g_r, g_cnt;
  logic                  cfg_ok;
  logic                  start_cmd, cfg_ok_in, zero_frame_in;
  logic                  accept, g_wrap, c_wrap, r_wrap, last_beat, new_out;
  logic [ADDR_W-1:0]     lb_addr;
  logic [GI_W-1:0]       g_idx;
  logic [DATA_WIDTH-1:0] hmax, pooled;
  logic [DATA_WIDTH-1:0] col_buf  [MAX_GROUPS];
  logic [DATA_WIDTH-1:0] line_buf [DEPTH];

  function automatic logic [DATA_WIDTH-1:0] lane_max(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] m;
    logic [LANE_WIDTH-1:0] la, lb;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      la = a[i*LANE_WIDTH +: LANE_WIDTH];
      lb = b[i*LANE_WIDTH +: LANE_WIDTH];
`ifdef MAXPOOL_SIGNED_EN
      m[i*LANE_WIDTH +: LANE_WIDTH] = ($signed(la) > $signed(lb)) ? la : lb;
`else
      m[i*LANE_WIDTH +: LANE_WIDTH] = (la > lb) ? la : lb;
`endif
    end
    return m;
  endfunction

  assign State     = state;
  assign start_cmd = (state == ST_IDLE) && (Control == 4'b0100);
  assign S_Ready   = (state == ST_RUN) && (!M_Valid || M_Ready);
  assign accept    = S_Valid && S_Ready;

  // Out-of-range frames are still counted through so the producer drains; they just never write or emit.
  assign cfg_ok_in = (cfg_width >= DIM_WIDTH'(2)) && (cfg_height >= DIM_WIDTH'(2)) &&
                     (cfg_groups != 6'd0) && (cfg_groups <= 6'(MAX_GROUPS)) &&
                     (cfg_width <= DIM_WIDTH'(MAX_WIDTH));
  assign zero_frame_in = (cfg_width == '0) || (cfg_height == '0) || (cfg_groups == 6'd0);

  assign g_wrap    = (g_cnt == g_r - 6'd1);
  assign c_wrap    = (c_cnt == w_r - DIM_WIDTH'(1));
  assign r_wrap    = (r_cnt == h_r - DIM_WIDTH'(1));
  assign last_beat = accept && g_wrap && c_wrap && r_wrap;

  assign g_idx   = g_cnt[GI_W-1:0];
  assign lb_addr = ADDR_W'(c_cnt >> 1) * ADDR_W'(g_r) + ADDR_W'(g_cnt);
  assign hmax    = lane_max(col_buf[g_idx], S_Data);
  assign pooled  = lane_max(line_buf[lb_addr], hmax);
  assign new_out = accept && cfg_ok && c_cnt[0] && r_cnt[0];

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_cmd) state_next = zero_frame_in ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (last_beat) state_next = ST_DRAIN;
      ST_DRAIN: if (!M_Valid || M_Ready) state_next = ST_DONE;
      ST_DONE:  if (Control == 4'b1111) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_r    <= '0;
      h_r    <= '0;
      g_r    <= '0;
      cfg_ok <= 1'b0;
      g_cnt  <= '0;
      c_cnt  <= '0;
      r_cnt  <= '0;
    end else if (start_cmd) begin
      w_r    <= cfg_width;
      h_r    <= cfg_height;
      g_r    <= cfg_groups;
      cfg_ok <= cfg_ok_in;
      g_cnt  <= '0;
      c_cnt  <= '0;
      r_cnt  <= '0;
    end else if (accept) begin
      if (g_wrap) begin
        g_cnt <= '0;
        if (c_wrap) begin
          c_cnt <= '0;
          r_cnt <= r_wrap ? '0 : r_cnt + DIM_WIDTH'(1);
        end else begin
          c_cnt <= c_cnt + DIM_WIDTH'(1);
        end
      end else begin
        g_cnt <= g_cnt + 6'd1;
      end
    end
  end

  // Buffers hold no state across frames, so they are left out of reset.
  always_ff @(posedge clk) begin
    if (accept && cfg_ok && !c_cnt[0]) col_buf[g_idx] <= S_Data;
    if (accept && cfg_ok && c_cnt[0] && !r_cnt[0]) line_buf[lb_addr] <= hmax;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      M_Valid    <= 1'b0;
      M_Data     <= '0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= (state_next == ST_DONE) && (state != ST_DONE);
      if (new_out) begin
        M_Valid <= 1'b1;
        M_Data  <= pooled;
      end else if (M_Ready) begin
        M_Valid <= 1'b0;
      end
    end
  end

endmodule
